// File: rtl/down_counter_timer.sv
// Loadable down-counting interval timer with start/busy/done handshake.
// Define DOWN_COUNTER_RELOAD_EN to compile in the auto-repeating RELOAD state.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] counter,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1
`ifdef DOWN_COUNTER_RELOAD_EN
    ,RELOAD = 2'd2
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] counter_nxt;
  logic             busy_nxt;
  logic             done_nxt;
`ifdef DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload, reload_nxt;
`endif

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    done_nxt    = 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
    reload_nxt  = reload;
`endif
    case (state)
      IDLE: begin
        if (load) begin
          counter_nxt = load_value;
`ifdef DOWN_COUNTER_RELOAD_EN
          reload_nxt  = load_value;
`endif
        end else if (start) begin
          if (counter != '0) state_nxt = RUN;
          else               done_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (load) begin
          counter_nxt = load_value;
`ifdef DOWN_COUNTER_RELOAD_EN
          reload_nxt  = load_value;
`endif
          state_nxt   = IDLE;
        end else if (counter == '0) begin
          // Never wrap below zero; only reachable if RUN is entered with zero.
          state_nxt = IDLE;
        end else if (!pause) begin
          counter_nxt = counter - WIDTH'(1);
          if (counter == WIDTH'(1)) begin
            done_nxt  = 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
            state_nxt = RELOAD;
`else
            state_nxt = IDLE;
`endif
          end
        end
      end
`ifdef DOWN_COUNTER_RELOAD_EN
      RELOAD: begin
        if (load) begin
          counter_nxt = load_value;
          reload_nxt  = load_value;
          state_nxt   = IDLE;
        end else begin
          counter_nxt = reload;
          state_nxt   = RUN;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload  <= '0;
`endif
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload  <= reload_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer; expected outputs are queued per step
// and checked one edge later. Covers both builds of DOWN_COUNTER_RELOAD_EN.
module tb_down_counter_timer;

`ifdef DOWN_COUNTER_RELOAD_EN
  localparam bit RL = 1'b1;
`else
  localparam bit RL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] counter;
  logic       busy;
  logic       done;

  typedef struct {
    string      tag;
    logic [3:0] c;
    logic       b;
    logic       d;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .counter(counter), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input string tag, input logic ld, input logic [3:0] lv,
                      input logic st, input logic pa, input logic rs,
                      input logic [3:0] ec, input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    load = ld; load_value = lv; start = st; pause = pa; reset = rs;
    q.push_back('{tag: tag, c: ec, b: eb, d: ed});
    @(posedge clk);
    #1;
    n_vec++;
    assert (q.size() > 0) else begin
      n_err++;
      $error("FAIL %s scoreboard empty got size %0d want >0", tag, q.size());
    end
    e = q.pop_front();
    n_vec++;
    assert (counter === e.c) else begin
      n_err++;
      $error("FAIL %s counter got %0d want %0d", e.tag, counter, e.c);
    end
    n_vec++;
    assert (busy === e.b) else begin
      n_err++;
      $error("FAIL %s busy got %b want %b", e.tag, busy, e.b);
    end
    n_vec++;
    assert (done === e.d) else begin
      n_err++;
      $error("FAIL %s done got %b want %b", e.tag, done, e.d);
    end
  endtask

  initial begin
    // reset state
    step("reset", 0, 0, 0, 0, 1, 4'd0, 0, 0);
    step("idle", 0, 0, 0, 0, 0, 4'd0, 0, 0);

    // zero-count start: single done, busy stays low
    step("zero_start", 0, 0, 1, 0, 0, 4'd0, 0, 1);
    step("zero_after", 0, 0, 0, 0, 0, 4'd0, 0, 0);
    step("zero_after2", 0, 0, 0, 0, 0, 4'd0, 0, 0);

    // one-shot count of 5
    step("os_load", 1, 4'd5, 0, 0, 0, 4'd5, 0, 0);
    step("os_start", 0, 0, 1, 0, 0, 4'd5, 1, 0);
    for (int j = 1; j <= 5; j++)
      step("os_run", 0, 0, 0, 0, 0, 4'(5 - j), (j < 5) | RL, j == 5);
    step("os_clear", 1, 4'd0, 0, 0, 0, 4'd0, 0, 0);

    // pause for 3 cycles mid-count
    step("pz_load", 1, 4'd4, 0, 0, 0, 4'd4, 0, 0);
    step("pz_start", 0, 0, 1, 0, 0, 4'd4, 1, 0);
    step("pz_run", 0, 0, 0, 0, 0, 4'd3, 1, 0);
    for (int j = 0; j < 3; j++)
      step("pz_hold", 0, 0, 0, 1, 0, 4'd3, 1, 0);
    step("pz_run", 0, 0, 0, 0, 0, 4'd2, 1, 0);
    step("pz_run", 0, 0, 0, 0, 0, 4'd1, 1, 0);
    step("pz_done", 0, 0, 0, 0, 0, 4'd0, RL, 1);
    step("pz_clear", 1, 4'd0, 0, 0, 0, 4'd0, 0, 0);

    // abort by load mid-run; load beats pause; start during run ignored
    step("ab_load", 1, 4'd7, 0, 0, 0, 4'd7, 0, 0);
    step("ab_start", 0, 0, 1, 0, 0, 4'd7, 1, 0);
    step("ab_run", 0, 0, 1, 0, 0, 4'd6, 1, 0);
    step("ab_run", 0, 0, 0, 0, 0, 4'd5, 1, 0);
    step("ab_run", 0, 0, 0, 0, 0, 4'd4, 1, 0);
    step("ab_run", 0, 0, 0, 0, 0, 4'd3, 1, 0);
    step("ab_abort", 1, 4'd2, 0, 1, 0, 4'd2, 0, 0);
    step("ab_after", 0, 0, 0, 0, 0, 4'd2, 0, 0);
    step("ab_after2", 0, 0, 0, 0, 0, 4'd2, 0, 0);

    // load and start on the same idle edge: load wins
    step("ls_both", 1, 4'd6, 1, 0, 0, 4'd6, 0, 0);
    step("ls_after", 0, 0, 0, 0, 0, 4'd6, 0, 0);

    // maximum value 15
    step("mx_load", 1, 4'd15, 0, 0, 0, 4'd15, 0, 0);
    step("mx_start", 0, 0, 1, 0, 0, 4'd15, 1, 0);
    for (int j = 1; j <= 15; j++)
      step("mx_run", 0, 0, 0, 0, 0, 4'(15 - j), (j < 15) | RL, j == 15);
    step("mx_clear", 1, 4'd0, 0, 0, 0, 4'd0, 0, 0);

    // reset in the middle of a run
    step("rr_load", 1, 4'd9, 0, 0, 0, 4'd9, 0, 0);
    step("rr_start", 0, 0, 1, 0, 0, 4'd9, 1, 0);
    step("rr_run", 0, 0, 0, 0, 0, 4'd8, 1, 0);
    step("rr_reset", 0, 0, 0, 0, 1, 4'd0, 0, 0);
    for (int j = 0; j < 4; j++)
      step("rr_after", 0, 0, 0, 0, 0, 4'd0, 0, 0);

`ifdef DOWN_COUNTER_RELOAD_EN
    // auto-reload: period 4, pause ignored in RELOAD
    step("rl_load", 1, 4'd3, 0, 0, 0, 4'd3, 0, 0);
    step("rl_start", 0, 0, 1, 0, 0, 4'd3, 1, 0);
    for (int p = 0; p < 3; p++) begin
      step("rl_run", 0, 0, 0, 0, 0, 4'd2, 1, 0);
      step("rl_run", 0, 0, 0, 0, 0, 4'd1, 1, 0);
      step("rl_done", 0, 0, 0, 0, 0, 4'd0, 1, 1);
      step("rl_reload", 0, 0, 1, 1, 0, 4'd3, 1, 0);
    end
    step("rl_abort", 1, 4'd5, 0, 0, 0, 4'd5, 0, 0);
    step("rl_idle", 0, 0, 0, 0, 0, 4'd5, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
